// File: rtl/vga_pkg.sv
// vga_pkg: shared types and default timing for the VGA display path.
// Provides the 12-bit colour struct, 640x480@60 timing defaults and the
// address software writes to request a frame-buffer swap.
package vga_pkg;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } vga_color_t;

  // 640x480@60 timing, pixel clock 25.175 MHz
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  // Framebuffer is the screen downscaled by 4 in each axis (160x120)
  localparam int DEF_SCALE_SHIFT = 2;

  // Bus address that toggles which frame buffer is displayed
  localparam logic [31:0] SWAP_ADDR = 32'h1003_0000;

endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line: fixed-depth shift register used to align raster control
// bits with the frame-memory read latency.
// Ports: i_clk, i_reset_n (async, active-low), d (input word), q (word
// delayed DEPTH clocks; DEPTH = 0 is a combinational passthrough).
module vga_delay_line #(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_pass
      // Clock and reset have no function without storage
      logic unused_clk_rst;
      assign unused_clk_rst = i_clk ^ i_reset_n;
      assign q = d;
    end else begin : g_pipe
      logic [WIDTH-1:0] stage [DEPTH];

      always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
          for (int i = 0; i < DEPTH; i++) stage[i] <= RESET_VAL;
        end else begin
          stage[0] <= d;
          for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
      end

      assign q = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_scanout.sv
// vga_scanout: raster timing generator and pin driver for the VGA frame memory.
// Ports: i_clk/i_reset_n; o_pxlX/o_pxlY read coordinates (0 outside active
// video); i_color returned RD_LATENCY clocks later; o_r/o_g/o_b/o_hsync/o_vsync
// registered pins, RD_LATENCY+1 clocks behind the counters; o_vblank and
// o_frame_start tell software when a buffer swap will not tear.
module vga_scanout
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE    = DEF_H_ACTIVE,
  parameter int   H_FP        = DEF_H_FP,
  parameter int   H_SYNC      = DEF_H_SYNC,
  parameter int   H_BP        = DEF_H_BP,
  parameter int   V_ACTIVE    = DEF_V_ACTIVE,
  parameter int   V_FP        = DEF_V_FP,
  parameter int   V_SYNC      = DEF_V_SYNC,
  parameter int   V_BP        = DEF_V_BP,
  parameter int   SCALE_SHIFT = DEF_SCALE_SHIFT,
  parameter int   RD_LATENCY  = 1,     // 0..4
  parameter logic SYNC_POL    = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  vga_color_t  i_color,
  output logic [7:0]  o_pxlX,
  output logic [7:0]  o_pxlY,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic [3:0]  o_r,
  output logic [3:0]  o_g,
  output logic [3:0]  o_b,
  output logic        o_vblank,
  output logic        o_frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

  // Delay-line word: {active, hsync, vsync}; idles as blank with syncs deasserted
  localparam logic [2:0] CTRL_IDLE = {1'b0, ~SYNC_POL, ~SYNC_POL};

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          h_wrap;
  logic          v_wrap;
  logic          active;
  logic          hsync_raw;
  logic          vsync_raw;
  logic [2:0]    ctrl_raw;
  logic [2:0]    ctrl_dly;

  assign h_wrap = (h_cnt == H_LAST);
  assign v_wrap = (v_cnt == V_LAST);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      if (h_wrap) begin
        h_cnt <= '0;
        v_cnt <= v_wrap ? '0 : v_cnt + VW'(1);
      end else begin
        h_cnt <= h_cnt + HW'(1);
      end
    end
  end

  always_comb begin
    active    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    hsync_raw = ((h_cnt >= HS_START) && (h_cnt < HS_END)) ? SYNC_POL : ~SYNC_POL;
    vsync_raw = ((v_cnt >= VS_START) && (v_cnt < VS_END)) ? SYNC_POL : ~SYNC_POL;
    o_vblank  = (v_cnt >= V_ACT);
    o_pxlX    = '0;
    o_pxlY    = '0;
    if (active) begin
      o_pxlX = 8'(h_cnt >> SCALE_SHIFT);
      o_pxlY = 8'(v_cnt >> SCALE_SHIFT);
    end
  end

  assign ctrl_raw = {active, hsync_raw, vsync_raw};

  // Holds the control bits back by the memory read latency so they line up
  // with the colour returned for the same raster position.
  vga_delay_line #(
    .WIDTH     (3),
    .DEPTH     (RD_LATENCY),
    .RESET_VAL (CTRL_IDLE)
  ) u_ctrl_dly (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .d         (ctrl_raw),
    .q         (ctrl_dly)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_r           <= '0;
      o_g           <= '0;
      o_b           <= '0;
      o_hsync       <= ~SYNC_POL;
      o_vsync       <= ~SYNC_POL;
      o_frame_start <= 1'b0;
    end else begin
      o_r     <= ctrl_dly[2] ? i_color.r : 4'h0;
      o_g     <= ctrl_dly[2] ? i_color.g : 4'h0;
      o_b     <= ctrl_dly[2] ? i_color.b : 4'h0;
      o_hsync <= ctrl_dly[1];
      o_vsync <= ctrl_dly[0];
      // Registered from the wrap condition so the pulse coincides with the
      // counters sitting at (0,0); never fires on the first frame after reset.
      o_frame_start <= h_wrap && v_wrap;
    end
  end

endmodule

// File: tb/tb_vga_scanout.sv
module tb_vga_scanout;
  import vga_pkg::*;

  // Reduced timing for whole-frame checks on the second instance
  localparam int SHA = 40, SHF = 4, SHS = 8, SHB = 6;
  localparam int SVA = 20, SVF = 2, SVS = 2, SVB = 3;
  localparam int SHT = SHA + SHF + SHS + SHB;   // 58
  localparam int SVT = SVA + SVF + SVS + SVB;   // 27
  localparam int FT  = SHT * SVT;               // clocks per frame
  localparam int SL  = 2;                       // read latency of small instance
  localparam int SS  = 2;                       // scale shift
  localparam logic SP = 1'b1;                   // small instance: active-high syncs

  logic clk;
  logic rst_d_n, rst_s_n;

  // Default-timing instance signals
  vga_color_t d_color;
  logic [7:0] d_x, d_y;
  logic       d_hsync, d_vsync, d_vb, d_fs;
  logic [3:0] d_r, d_g, d_b;

  // Small-timing instance signals
  vga_color_t s_color;
  vga_color_t c1, c2;
  logic [7:0] s_x, s_y;
  logic       s_hsync, s_vsync, s_vb, s_fs;
  logic [3:0] s_r, s_g, s_b;

  logic [11:0] mem [0:255][0:255];

  int n_checks = 0;
  int n_errors = 0;
  int n_s;          // clock edges since small-instance reset release
  bit chk_en = 0;
  int fs_cnt, fs_last, fs_gap;

  vga_scanout dut_d (
    .i_clk(clk), .i_reset_n(rst_d_n), .i_color(d_color),
    .o_pxlX(d_x), .o_pxlY(d_y), .o_hsync(d_hsync), .o_vsync(d_vsync),
    .o_r(d_r), .o_g(d_g), .o_b(d_b), .o_vblank(d_vb), .o_frame_start(d_fs)
  );

  vga_scanout #(
    .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
    .SCALE_SHIFT(SS), .RD_LATENCY(SL), .SYNC_POL(SP)
  ) dut_s (
    .i_clk(clk), .i_reset_n(rst_s_n), .i_color(s_color),
    .o_pxlX(s_x), .o_pxlY(s_y), .o_hsync(s_hsync), .o_vsync(s_vsync),
    .o_r(s_r), .o_g(s_g), .o_b(s_b), .o_vblank(s_vb), .o_frame_start(s_fs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame memory models: small one is a 2-deep synchronous read of mem,
  // default one returns ABC only at framebuffer coordinate (1,2).
  always @(posedge clk) begin
    c1      <= vga_color_t'(mem[s_y][s_x]);
    c2      <= c1;
    d_color <= (d_x == 8'd1 && d_y == 8'd2) ? vga_color_t'(12'hABC) : vga_color_t'(12'h000);
  end
  assign s_color = c2;

  always @(posedge clk or negedge rst_s_n) begin
    if (!rst_s_n) n_s <= 0;
    else          n_s <= n_s + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Expected small-instance outputs after n clock edges since reset release,
  // derived from raster position arithmetic.
  function automatic logic [31:0] model(input int n);
    int p, h, v, q, qh, qv;
    logic act, hs, vs, fs, vb;
    logic [11:0] col;
    logic [7:0]  x, y;
    p  = n % FT;
    h  = p % SHT;
    v  = p / SHT;
    x  = (h < SHA && v < SVA) ? 8'(h >> SS) : 8'd0;
    y  = (h < SHA && v < SVA) ? 8'(v >> SS) : 8'd0;
    vb = (v >= SVA);
    fs = (n >= FT) && (p == 0);
    act = 1'b0; hs = ~SP; vs = ~SP; col = 12'h000;
    if (n >= SL + 1) begin
      q  = (n - SL - 1) % FT;
      qh = q % SHT;
      qv = q / SHT;
      act = (qh < SHA) && (qv < SVA);
      hs  = (qh >= SHA + SHF && qh < SHA + SHF + SHS) ? SP : ~SP;
      vs  = (qv >= SVA + SVF && qv < SVA + SVF + SVS) ? SP : ~SP;
      col = act ? mem[qv >> SS][qh >> SS] : 12'h000;
    end
    return {hs, vs, col, fs, vb, x, y};
  endfunction

  function automatic logic [31:0] s_vec();
    return {s_hsync, s_vsync, s_r, s_g, s_b, s_fs, s_vb, s_x, s_y};
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check_eq("pins", s_vec(), model(n_s));
      if (s_fs) begin
        fs_cnt++;
        fs_gap  = n_s - fs_last;
        fs_last = n_s;
      end
    end
  end

  task automatic fill(input int mode);
    for (int yy = 0; yy < 16; yy++)
      for (int xx = 0; xx < 16; xx++)
        case (mode)
          0:       mem[yy][xx] = 12'($urandom);
          1:       mem[yy][xx] = 12'hFFF;
          default: mem[yy][xx] = (xx == 1 && yy == 2) ? 12'hABC : 12'h000;
        endcase
  endtask

  initial begin
    int fall0, fall1, rise0, hh, vv;
    logic prev_hs;
    logic [11:0] exp_col;
    rst_d_n = 1'b1;
    rst_s_n = 1'b1;
    fill(0);
    #1;
    rst_d_n = 1'b0;
    rst_s_n = 1'b0;
    #1;
    chk_en = 1;
    check_eq("d_reset", {8'h0, d_hsync, d_vsync, d_r, d_g, d_b, d_fs, d_vb, d_x, d_y},
             {8'h0, 1'b1, 1'b1, 12'h000, 1'b0, 1'b0, 8'd0, 8'd0});

    // Default 640x480 instance: first twelve lines
    @(negedge clk);
    rst_d_n = 1'b1;
    fall0 = -1; fall1 = -1; rise0 = -1; prev_hs = 1'b1;
    for (int m = 1; m <= 12 * 800; m++) begin
      @(posedge clk);
      #1;
      if (prev_hs && !d_hsync) begin
        if (fall0 < 0) fall0 = m;
        else if (fall1 < 0) fall1 = m;
      end
      if (!prev_hs && d_hsync && rise0 < 0) rise0 = m;
      prev_hs = d_hsync;
      if (m == 639)
        check_eq("d_xy_639_0", {15'h0, d_vb, d_x, d_y}, {15'h0, 1'b0, 8'd159, 8'd0});
      if (m == 640)
        check_eq("d_xy_640_0", {15'h0, d_vb, d_x, d_y}, {15'h0, 1'b0, 8'd0, 8'd0});
      if (m == 9 * 800 + 5)
        check_eq("d_xy_5_9", {15'h0, d_vb, d_x, d_y}, {15'h0, 1'b0, 8'd1, 8'd2});
      if (m >= 8 * 800 + 2 && m <= 11 * 800 + 17 && ((m - 2) % 800) < 16) begin
        hh = (m - 2) % 800;
        vv = (m - 2) / 800;
        exp_col = (hh >= 4 && hh <= 7 && vv >= 8 && vv <= 11) ? 12'hABC : 12'h000;
        check_eq("d_color", {20'h0, d_r, d_g, d_b}, {20'h0, exp_col});
      end
    end
    check_eq("d_hs_first_fall", 32'(fall0), 32'd658);
    check_eq("d_hs_width", 32'(rise0 - fall0), 32'd96);
    check_eq("d_hs_period", 32'(fall1 - fall0), 32'd800);
    check_eq("d_vs_idle", {31'h0, d_vsync}, 32'd1);

    // Small instance: three frames from reset with random framebuffer
    fs_cnt = 0; fs_last = 0; fs_gap = 0;
    @(posedge clk);
    #3;
    rst_s_n = 1'b1;
    repeat (3 * FT - 1) @(posedge clk);
    @(negedge clk);
    #1;
    check_eq("fs_count", 32'(fs_cnt), 32'd2);
    check_eq("fs_gap", 32'(fs_gap), 32'(FT));

    // Random mid-frame resets, each followed by a new framebuffer pattern
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #3;
      rst_s_n = 1'b0;
      #1;
      check_eq("reset_imm", s_vec(), model(0));
      fill(i % 3);
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #3;
      rst_s_n = 1'b1;
      repeat ($urandom_range(300, 3000)) @(posedge clk);
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
